// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//
// Purpose:
//   Bundles the request/response signals between the multicycle CPU datapath
//   (the master, issuing LW/SW in its MEM state) and the data-memory responder
//   (the slave).
//
// Signals:
//   req    master -> slave  access request, sampled only while the slave is idle
//   we     master -> slave  1 = write (SW), 0 = read (LW)
//   addr   master -> slave  32-bit byte address
//   wdata  master -> slave  write data (DATA_W bits)
//   rdata  slave -> master  registered read data (DATA_W bits)
//   ready  slave -> master  one-cycle completion pulse
//   busy   slave -> master  access in flight, up to and including the ready cycle
//   err    slave -> master  misaligned-access flag, valid with ready
//
// Modports:
//   master  CPU side
//   slave   memory responder side
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ready,
        input  busy,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ready,
        output busy,
        output err
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Memory-side responder for the multicycle CPU's data-memory accesses.
//   Takes one request at a time, inserts WAIT_CYCLES wait states and then
//   completes with a one-cycle ready pulse. Reads land in a registered rdata
//   that holds its value until the next completed read.
//
// Parameters:
//   ADDR_W       word-address bits; the array holds 2**ADDR_W words
//   DATA_W       data word width
//   WAIT_CYCLES  wait states inserted before completion (0..15)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    data_mem_responder_if.slave (req/we/addr/wdata in,
//          rdata/ready/busy/err out)
//
// Configuration macro:
//   MEM_ALIGN_CHECK_EN  when defined, an access with addr[1:0] != 0 completes
//                       with normal latency but raises err for the ready cycle;
//                       its write is dropped and rdata is left untouched.
//                       When undefined, addr[1:0] is ignored and err is 0.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    data_mem_responder_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // With zero wait states the access goes straight from IDLE to RESP, so
    // the counter preload is only meaningful for WAIT_CYCLES >= 1.
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        wait_cnt;

    logic              acc_we_q;
    logic [ADDR_W-1:0] acc_idx_q;
    logic [DATA_W-1:0] acc_wdata_q;

    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] req_idx;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_idx;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_misaligned;
    logic              enter_resp;
    logic              mem_write;
    logic              mem_read;

    // Address bits above the word index are dropped, so high addresses alias
    // back onto low words.
    assign req_idx = bus.addr[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

    // The array access happens on the edge that enters RESP. When there are
    // no wait states that edge is the acceptance edge itself, so the live bus
    // values must be used instead of the captured copies.
    always_comb begin
        eff_we     = acc_we_q;
        eff_idx    = acc_idx_q;
        eff_wdata  = acc_wdata_q;
        enter_resp = 1'b0;
        if (state == S_IDLE) begin
            eff_we     = bus.we;
            eff_idx    = req_idx;
            eff_wdata  = bus.wdata;
            enter_resp = bus.req && NO_WAIT;
        end else if (state == S_WAIT) begin
            enter_resp = (wait_cnt == 4'd0);
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic acc_misaligned_q;
    logic req_misaligned;
    logic err_q;

    assign req_misaligned = |bus.addr[1:0];
    assign eff_misaligned = (state == S_IDLE) ? req_misaligned : acc_misaligned_q;

    // The misalignment flag is captured with the request and reported as err
    // only during the ready cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_misaligned_q <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.req) begin
                acc_misaligned_q <= req_misaligned;
            end
            err_q <= enter_resp && eff_misaligned;
        end
    end

    assign bus.err = err_q;
`else
    assign eff_misaligned = 1'b0;
    assign bus.err        = 1'b0;
`endif

    assign mem_write = enter_resp &&  eff_we && !eff_misaligned;
    assign mem_read  = enter_resp && !eff_we && !eff_misaligned;

    // Control FSM, capture registers and the registered read port. Reset
    // throws away any access in flight; since the array write is gated by
    // the FSM state, an abandoned write never reaches the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            acc_we_q    <= 1'b0;
            acc_idx_q   <= '0;
            acc_wdata_q <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            if (mem_read) begin
                rdata_q <= mem[eff_idx];
            end
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        acc_we_q    <= bus.we;
                        acc_idx_q   <= req_idx;
                        acc_wdata_q <= bus.wdata;
                        busy_q      <= 1'b1;
                        if (NO_WAIT) begin
                            state <= S_RESP;
                        end else begin
                            wait_cnt <= CNT_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // The data array itself has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Purpose:
//   Self-checking bench for data_mem_responder with WAIT_CYCLES = 2 and
//   ADDR_W = 10. Stimulus pushes the expected completion (rdata, err and the
//   cycle in which ready must appear) into a scoreboard queue; a monitor pops
//   and compares on every ready pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_data_mem_responder;

    localparam int W = 2;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int   cyc         = 0;
    int   tests       = 0;
    int   fails       = 0;
    int   ready_count = 0;
    logic [31:0] model_rdata = 32'h0;
    exp_t sb[$];

    data_mem_responder_if #(.DATA_W(32)) bus ();

    data_mem_responder #(
        .ADDR_W      (10),
        .DATA_W      (32),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((bus.busy !== 1'b0 || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeoutFail(name);
    endtask

    // Issue one access; returns #1 after the acceptance edge.
    task automatic applyStimulus(input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] exp_read,
                                 input logic exp_err);
        waitIdle("idle_before_req");
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        if (!w && !exp_err) model_rdata = exp_read;
        sb.push_back('{model_rdata, exp_err, cyc + W});
    endtask

    // Monitor: compare every completion against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                exp_t e;
                ready_count++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_ready: got ready=1, expected no pending access (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ready_cycle", cyc, e.cyc);
                    checkOutput("rdata", bus.rdata, e.rdata);
                    checkOutput("err", {31'b0, bus.err}, {31'b0, e.err});
                    checkOutput("busy_with_ready", {31'b0, bus.busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_ready", {31'b0, bus.ready}, 32'd0);
        checkOutput("reset_busy",  {31'b0, bus.busy},  32'd0);
        checkOutput("reset_err",   {31'b0, bus.err},   32'd0);
        checkOutput("reset_rdata", bus.rdata, 32'h0);

        // Write with explicit busy/ready timing around the acceptance edge.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        checkOutput("e0_busy",  {31'b0, bus.busy},  32'd1);
        checkOutput("e0_ready", {31'b0, bus.ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("e1_ready", {31'b0, bus.ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("e2_ready", {31'b0, bus.ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("e3_busy",  {31'b0, bus.busy},  32'd0);
        checkOutput("e3_ready", {31'b0, bus.ready}, 32'd0);

        // Read back and confirm rdata holds afterwards.
        applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        waitIdle("read_done");
        repeat (2) @(negedge clk);
        checkOutput("rdata_held", bus.rdata, 32'hDEADBEEF);

        // Address wrap: 0x1000 aliases onto word 0.
        applyStimulus(1'b1, 32'h1000, 32'h12345678, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0000, 32'h0, 32'h12345678, 1'b0);
        waitIdle("wrap_done");
        checkOutput("rdata_after_write_unchanged", bus.rdata, 32'h12345678);

        // req held high for 8 cycles: accepted at relative edges 0 and 4 only.
        waitIdle("held_start");
        rc = ready_count;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req  = 1'b1;
            bus.we   = 1'b0;
            bus.addr = (k < 4) ? 32'h10 : 32'h0;
            @(posedge clk);
            #1;
            if (k == 0) begin
                model_rdata = 32'hDEADBEEF;
                sb.push_back('{model_rdata, 1'b0, cyc + W});
            end
            if (k == 4) begin
                model_rdata = 32'h12345678;
                sb.push_back('{model_rdata, 1'b0, cyc + W});
            end
        end
        bus.req = 1'b0;
        waitIdle("held_done");
        checkOutput("held_req_pulses", ready_count - rc, 32'd2);

        // Known contents at 0x20, then an aborted write of A5A5A5A5.
        applyStimulus(1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        reset = 1'b1;
        sb.delete();
        model_rdata = 32'h0;
        rc = ready_count;
        #2;
        checkOutput("abort_rdata", bus.rdata, 32'h0);
        checkOutput("abort_busy",  {31'b0, bus.busy},  32'd0);
        checkOutput("abort_ready", {31'b0, bus.ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_pulse", ready_count - rc, 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // Misaligned write to 0x22.
        applyStimulus(1'b1, 32'h22, 32'hFFFFFFFF, 32'h0, ALIGN_EN);
        applyStimulus(1'b0, 32'h20, 32'h0, ALIGN_EN ? 32'h11111111 : 32'hFFFFFFFF, 1'b0);
        waitIdle("final_done");
        checkOutput("final_err_clear", {31'b0, bus.err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
